// File: rtl/eth_rx_frame_checker.sv
// Receive-side frame checker for MAC loopback bring-up: verifies the incrementing-byte
// payload pattern, the length against ruser and the CRC verdict, and keeps saturating statistics.
module eth_rx_frame_checker #(
  parameter int P_CRC_TIMEOUT   = 16,
  parameter bit P_CHECK_PATTERN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [63:0] s_axis_rdata,
  input  logic [79:0] s_axis_ruser,
  input  logic [7:0]  s_axis_rkeep,
  input  logic        s_axis_rlast,
  input  logic        s_axis_rvalid,
  input  logic        i_crc_valid,
  input  logic        i_crc_error,
  input  logic        i_clr_cnt,
  output logic [31:0] o_frame_cnt,
  output logic [47:0] o_byte_cnt,
  output logic [15:0] o_crc_err_cnt,
  output logic [15:0] o_pat_err_cnt,
  output logic [15:0] o_len_err_cnt,
  output logic        o_frame_done,
  output logic        o_frame_ok
);

  localparam int TW = $clog2(P_CRC_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_WAIT} state_t;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  // Legal last-beat keep: non-zero and of the form 1..10..0 (inverse is 0..01..1).
  function automatic logic keep_legal(input logic [7:0] k);
    logic [7:0] inv;
    inv = ~k;
    return (k != 8'h00) && ((inv & (inv + 8'd1)) == 8'h00);
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] a);
    return (a == 32'hFFFF_FFFF) ? a : a + 32'd1;
  endfunction

  function automatic logic [47:0] sat_add48(input logic [47:0] a, input logic [15:0] b);
    logic [48:0] s;
    s = {1'b0, a} + {33'd0, b};
    return s[48] ? 48'hFFFF_FFFF_FFFF : s[47:0];
  endfunction

  state_t        state, state_nxt;
  logic [TW-1:0] timer;

  logic        first_beat, beat_act, res_wait, res_last, resolve;
  logic [7:0]  seed;
  logic [15:0] base_len, base_bytes, cur_bytes;
  logic        keep_err, lane_mis, cur_len_err, cur_pat_err;
  logic        fin_crc, fin_len, fin_pat;
  logic [15:0] fin_bytes;

  logic [7:0]  exp_byte;
  logic [15:0] exp_len, frm_bytes;
  logic        len_err, pat_err;

  logic        done_p1, ok_p1;
  logic [31:0] frame_cnt;
  logic [47:0] byte_cnt;
  logic [15:0] crc_err_cnt, pat_err_cnt, len_err_cnt;

  logic unused_ruser;
  assign unused_ruser = ^s_axis_ruser[79:16];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // A new first beat may land in the cycle the pending frame resolves; the
  // crc_valid of that cycle belongs to the pending frame, not to the new one.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (s_axis_rvalid)
                state_nxt = s_axis_rlast ? (i_crc_valid ? S_IDLE : S_WAIT) : S_DATA;
      S_DATA: if (s_axis_rvalid && s_axis_rlast)
                state_nxt = i_crc_valid ? S_IDLE : S_WAIT;
      S_WAIT: if (res_wait) begin
                if (s_axis_rvalid) state_nxt = s_axis_rlast ? S_WAIT : S_DATA;
                else               state_nxt = S_IDLE;
              end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    res_wait   = (state == S_WAIT) && (i_crc_valid || (timer == TW'(P_CRC_TIMEOUT - 1)));
    beat_act   = s_axis_rvalid && ((state != S_WAIT) || res_wait);
    first_beat = (state != S_DATA);
    res_last   = s_axis_rvalid && s_axis_rlast && i_crc_valid && (state != S_WAIT);
    resolve    = res_wait || res_last;
  end

  always_comb begin
    seed       = first_beat ? s_axis_rdata[63:56] : exp_byte;
    base_len   = first_beat ? s_axis_ruser[15:0] : exp_len;
    base_bytes = first_beat ? 16'd0 : frm_bytes;
    cur_bytes  = sat_add16(base_bytes, {12'd0, popcnt8(s_axis_rkeep)});
    keep_err   = s_axis_rlast ? !keep_legal(s_axis_rkeep) : (s_axis_rkeep != 8'hFF);
    lane_mis   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (s_axis_rkeep[7-k] && (s_axis_rdata[63-8*k -: 8] != seed + 8'(k))) lane_mis = 1'b1;
    end
    cur_len_err = (!first_beat && len_err) || keep_err ||
                  (s_axis_rlast && (cur_bytes != base_len));
    cur_pat_err = (!first_beat && pat_err) || (P_CHECK_PATTERN && lane_mis);
    if (res_last) begin
      fin_crc   = i_crc_error;
      fin_len   = cur_len_err;
      fin_pat   = cur_pat_err;
      fin_bytes = cur_bytes;
    end else begin
      fin_crc   = i_crc_valid ? i_crc_error : 1'b1;
      fin_len   = len_err;
      fin_pat   = pat_err;
      fin_bytes = frm_bytes;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                            timer <= '0;
    else if ((state != S_WAIT) || res_wait)  timer <= '0;
    else                                     timer <= timer + TW'(1);
  end

  // Per-frame accumulators: the first beat overrides all history, so no reset needed.
  always_ff @(posedge i_clk) begin
    if (beat_act) begin
      exp_byte  <= seed + 8'd8;
      exp_len   <= base_len;
      frm_bytes <= cur_bytes;
      len_err   <= cur_len_err;
      pat_err   <= cur_pat_err;
    end else if ((state == S_WAIT) && s_axis_rvalid) begin
      len_err   <= 1'b1;
    end
  end

  // Completion stage: result strobe and statistics one cycle after resolution.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      done_p1 <= 1'b0;
      ok_p1   <= 1'b0;
    end else begin
      done_p1 <= resolve;
      ok_p1   <= resolve && !(fin_crc || fin_len || fin_pat);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr_cnt) begin
      frame_cnt   <= '0;
      byte_cnt    <= '0;
      crc_err_cnt <= '0;
      pat_err_cnt <= '0;
      len_err_cnt <= '0;
    end else if (resolve) begin
      frame_cnt   <= sat_inc32(frame_cnt);
      byte_cnt    <= sat_add48(byte_cnt, fin_bytes);
      crc_err_cnt <= sat_add16(crc_err_cnt, {15'd0, fin_crc});
      pat_err_cnt <= sat_add16(pat_err_cnt, {15'd0, fin_pat});
      len_err_cnt <= sat_add16(len_err_cnt, {15'd0, fin_len});
    end
  end

  assign o_frame_done  = done_p1;
  assign o_frame_ok    = ok_p1;
  assign o_frame_cnt   = frame_cnt;
  assign o_byte_cnt    = byte_cnt;
  assign o_crc_err_cnt = crc_err_cnt;
  assign o_pat_err_cnt = pat_err_cnt;
  assign o_len_err_cnt = len_err_cnt;

endmodule
